instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction prefetch queue between the synchronous instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues one read per cycle while it has credit. It tags each returned word with its PC and PC+1 and presents the entries in order to decode with a valid/ready handshake. A branch/jump redirect flushes the queue and any in-flight read.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- AW, 8, PC/address width
- DW, 32, instruction width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- enable  in  1  global run; 0 blocks issue and pop
- redirect  in  1  taken branch/jump or misprediction; flush and reload
- redirect_pc  in  AW  new fetch address, sampled when redirect=1
- imem_req  out  1  read issued this cycle
- imem_addr  out  AW  read address; always equals fetch_pc
- imem_rdata  in  DW  read data, valid the cycle after imem_req
- out_valid  out  1  head entry available
- out_instr  out  DW  head instruction
- out_pc  out  AW  address of head instruction
- out_pc_plus1  out  AW  out_pc+1 mod 2^AW
- out_ready  in  1  decode accepts (not stalled)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State:
  - fetch_pc
  - resp_pend: a read was issued last cycle
  - resp_pc: the PC of that read
  - resp_kill: discard flag for that read
  - FIFO storage, wr_ptr, rd_ptr, count
- Issue:
  - Condition: imem_req = enable & ~redirect & (count + resp_pend < DEPTH).
  - On issue: resp_pend←1, resp_pc←fetch_pc, fetch_pc←fetch_pc+1, wrapping 255→0 at AW=8.
- Response:
  - Applies when resp_pend=1 and resp_kill=0.
  - Pushes {resp_pc, imem_rdata}.
  - Capture is not gated by enable, so an in-flight word is never lost.
- Pop: out_valid & out_ready & enable removes the head.
- Push and pop in the same cycle leaves count unchanged. The credit rule guarantees no push into a full queue.
- Redirect has priority over push, pop and issue in its cycle:
  - count←0 and pointers←0.
  - fetch_pc←redirect_pc.
  - resp_kill←1 if a read is outstanding or issued this cycle.
  - out_valid is forced 0 in the redirect cycle.
- Reset has priority over redirect:
  - fetch_pc=0, count=0, pointers=0.
  - resp_pend=0, resp_kill=0.
  - out_valid=0, imem_req=0, imem_addr=0.
  - A response arriving in the cycle after reset is dropped.
- Outputs when out_valid=0: out_instr/out_pc hold the head slot contents. Consumers must ignore them.

## Timing
- Cold start, no bypass:
  - Reset released at edge 0.
  - imem_req=1, addr 0 in cycle 0.
  - Data pushed at edge 2.
  - out_valid=1 in cycle 2.
- Steady state: one instruction per cycle with out_ready=1.
- Redirect asserted in cycle t:
  - First req at redirect_pc in cycle t+1.
  - out_valid in cycle t+3, or t+2 with bypass.
- out_ready=0 for a long stall: the queue fills to DEPTH and imem_req drops, with at most DEPTH words buffered. Issue resumes the cycle after a pop frees credit.
- count, out_* are registered except under bypass (below).

## Configuration
- FETCHQ_BYPASS_EN defined:
  - Applies when count=0 and a valid, unkilled response arrives.
  - out_valid, out_instr and out_pc are driven combinationally from imem_rdata/resp_pc.
  - If out_ready & enable, the word is consumed without being written. Otherwise it is pushed.
  - Saves one cycle of fetch latency.
- Undefined: out_* come only from the FIFO head, and every word is queued for at least one cycle.

## Structure
- Package fetch_pkg holds:
  - AW/DW defaults
  - the fetch_entry_t struct {pc, instr}
  - the pointer-width function
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush/count.
  - Flush has priority.
  - No overflow protection; the parent's credit rule provides it.

## Test plan
- Reset, then out_ready=1 for 10 cycles, imem returns mem[a]=a+0x100 → out_pc 0,1,2,… one per cycle from cycle 2; out_instr=0x100+out_pc; out_pc_plus1=out_pc+1.
- out_ready=0 for 8 cycles after start, DEPTH=4 → count saturates at 4, imem_req=0 while full. Release yields out_pc 0..3 then 4 with no gap or duplicate.
- Redirect to 0x40 in a cycle with a read outstanding at 0x05 → 0x05's data never appears. Next out_pc=0x40, at t+3 (t+2 with FETCHQ_BYPASS_EN).
- fetch_pc=0xFE, free run → out_pc 0xFE, 0xFF, 0x00; out_pc_plus1 for 0xFF is 0x00.
- enable=0 for 3 cycles mid-stream with out_ready=1 → no pop, no req. The outstanding word is still captured (count+1). The sequence resumes intact.
- rst=0 for one cycle while queue holds 3 entries and a read is pending → count=0, out_valid=0 next cycle, restart at PC 0, stale response dropped.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// Provides default widths, the queue entry layout and the FIFO pointer sizing function.
package fetch_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic [DW_DEF-1:0] instr;
    } fetch_entry_t;

    // Index width for a power-of-two ring; a single-bit pointer is the floor.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO of fetch entries with push/pop/flush and occupancy count.
// Flush beats push/pop; the parent's credit scheme guarantees no push while full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_reg != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues credit-limited reads and feeds decode in order.
// Define FETCHQ_BYPASS_EN to forward a returning word straight to the output when the queue is empty.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    output logic                   imem_req,
    output logic [AW-1:0]          imem_addr,
    input  logic [DW-1:0]          imem_rdata,
    output logic                   out_valid,
    output logic [DW-1:0]          out_instr,
    output logic [AW-1:0]          out_pc,
    output logic [AW-1:0]          out_pc_plus1,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    logic [AW-1:0] fetch_pc_reg;
    logic [AW-1:0] resp_pc_reg;
    logic          resp_pend_reg;
    logic          resp_kill_reg;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    entry_t        head;
    entry_t        resp_entry;
    logic          issue;
    logic          resp_valid;
    logic          accept;
    logic          fifo_push;
    logic          fifo_pop;

    // Outstanding reads reserve a slot so a returning word always has room.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, resp_pend_reg};
    assign issue       = rst & enable & ~redirect & (credit_used < (CW+1)'(DEPTH));
    assign resp_valid  = resp_pend_reg & ~resp_kill_reg;
    assign resp_entry  = '{pc: resp_pc_reg, instr: imem_rdata};

`ifdef FETCHQ_BYPASS_EN
    logic bypass_active;

    assign bypass_active = resp_valid & (fifo_count == '0);
    assign out_valid     = rst & ~redirect & ((fifo_count != '0) | bypass_active);
    assign out_instr     = bypass_active ? imem_rdata  : head.instr;
    assign out_pc        = bypass_active ? resp_pc_reg : head.pc;
    assign accept        = out_valid & out_ready & enable;
    assign fifo_push     = resp_valid & ~(bypass_active & accept);
    assign fifo_pop      = accept & ~bypass_active;
`else
    assign out_valid = rst & ~redirect & (fifo_count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign accept    = out_valid & out_ready & enable;
    assign fifo_push = resp_valid;
    assign fifo_pop  = accept;
`endif

    assign out_pc_plus1 = out_pc + 1'b1;
    assign imem_req     = issue;
    assign imem_addr    = fetch_pc_reg;
    assign count        = fifo_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_reg  <= '0;
            resp_pc_reg   <= '0;
            resp_pend_reg <= 1'b0;
            resp_kill_reg <= 1'b0;
        end else begin
            resp_pend_reg <= issue;
            if (redirect) begin
                fetch_pc_reg  <= redirect_pc;
                // Anything tied to the old stream must not reach the queue.
                resp_kill_reg <= resp_pend_reg | issue;
            end else begin
                resp_kill_reg <= 1'b0;
                if (issue) begin
                    fetch_pc_reg <= fetch_pc_reg + 1'b1;
                    resp_pc_reg  <= fetch_pc_reg;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .wdata (resp_entry),
        .rdata (head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: expected PC stream per reset/redirect, checked on every accept.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 32;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int REDIR_LAT = BYP ? 2 : 3;
    localparam int STEADY    = BYP ? 0 : 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   enable = 1'b0;
    logic                   redirect = 1'b0;
    logic [AW-1:0]          redirect_pc = '0;
    logic                   imem_req;
    logic [AW-1:0]          imem_addr;
    logic [DW-1:0]          imem_rdata = '0;
    logic                   out_valid;
    logic [DW-1:0]          out_instr;
    logic [AW-1:0]          out_pc;
    logic [AW-1:0]          out_pc_plus1;
    logic                   out_ready = 1'b0;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] next_push = '0;
    logic [AW-1:0] mon_e;
    logic [AW-1:0] mon_e1;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus1 (out_pc_plus1),
        .out_ready    (out_ready),
        .count        (count)
    );

    // Synchronous memory: mem[a] = 0x100 + a; junk when no read was issued.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (32'h100 + 32'(imem_addr)) : $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 64) begin
            exp_q.push_back(next_push);
            next_push = next_push + 1'b1;
        end
    endtask

    task automatic restart_stream(input logic [AW-1:0] start);
        exp_q.delete();
        next_push = start;
        top_up();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        top_up();
    endtask

    // Reset is held for exactly one edge; returns early in cycle 0 of the new run.
    task automatic apply_reset();
        rst = 1'b0;
        redirect = 1'b0;
        restart_stream('0);
        step();
        rst = 1'b1;
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        restart_stream(pc);
    endtask

    // Monitor: every accepted word must be the next one of the expected stream.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && enable) begin
            accepts++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got pc 0x%0h, expected no output", out_pc);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_e1 = mon_e + 1'b1;
                $display("accept pc=%02h instr=%08h pc+1=%02h count=%0d", out_pc, out_instr, out_pc_plus1, count);
                check("out_pc", 32'(out_pc), 32'(mon_e));
                check("out_instr", out_instr, 32'h100 + 32'(mon_e));
                check("out_pc_plus1", 32'(out_pc_plus1), 32'(mon_e1));
            end
        end
    end

    initial begin
        int found;
        int first;
        int a0;

        // Cold start and steady stream
        enable = 1'b1;
        out_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        check("c0_imem_req", 32'(imem_req), 1);
        check("c0_imem_addr", 32'(imem_addr), 0);
        check("c0_out_valid", 32'(out_valid), 0);
        check("c0_count", 32'(count), 0);
        @(negedge clk);
        check("c1_out_valid", 32'(out_valid), 32'(BYP));
        @(negedge clk);
        check("c2_out_valid", 32'(out_valid), 1);
        check("c2_out_pc", 32'(out_pc), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("steady_valid", 32'(out_valid), 1);
        end

        // Enable low for three cycles: no req, no pop, in-flight word still lands
        step();
        enable = 1'b0;
        @(negedge clk);
        check("dis_count0", 32'(count), STEADY);
        check("dis_req0", 32'(imem_req), 0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            check("dis_count", 32'(count), STEADY + 1);
            check("dis_req", 32'(imem_req), 0);
        end
        step();
        enable = 1'b1;
        repeat (10) step();

        // Long stall: queue saturates, requests stop, release is gapless
        out_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                check("stall_count", 32'(count), DEPTH);
                check("stall_req", 32'(imem_req), 0);
            end
        end
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("release_valid", 32'(out_valid), 1);
        end

        // Redirect while the read of 0x05 is outstanding
        apply_reset();
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 8'h05) found = 1;
        end
        check("found_addr5", 32'(found), 1);
        step();
        do_redirect(8'h40);
        @(negedge clk);
        check("redir_valid", 32'(out_valid), 0);
        check("redir_req", 32'(imem_req), 0);
        step();
        redirect = 1'b0;
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("redir_req_t1", 32'(imem_req), 1);
                check("redir_addr_t1", 32'(imem_addr), 32'h40);
            end
            if (out_valid && first < 0) first = k;
        end
        check("redir_latency", 32'(first), REDIR_LAT);

        // PC wrap at the top of the address space
        step();
        do_redirect(8'hFE);
        step();
        redirect = 1'b0;
        repeat (8) step();

        // Reset with three entries queued and a read pending
        out_ready = 1'b0;
        apply_reset();
        repeat (3) step();
        @(negedge clk);
        check("pre_rst_count", 32'(count), 2);
        check("pre_rst_req", 32'(imem_req), 1);
        step();
        apply_reset();
        @(negedge clk);
        check("post_rst_count", 32'(count), 0);
        check("post_rst_valid", 32'(out_valid), 0);
        step();
        out_ready = 1'b1;
        repeat (10) step();

        // Randomised traffic
        a0 = accepts;
        for (int c = 0; c < 1500; c++) begin
            step();
            redirect  = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else if ($urandom_range(0, 29) == 0) begin
                do_redirect(8'($urandom));
            end
        end
        check("random_progress", 32'(accepts - a0 > 300), 1);

        // Drain: full throughput must resume
        step();
        redirect = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();
        a0 = accepts;
        repeat (30) step();
        check("drain_rate", 32'(accepts - a0 >= 28), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
